// File: rtl/led_ctrl_pkg.sv
// Shared types, LED pattern tables and pattern helpers for the LED pattern controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {MODE_OFF, MODE_BAR, MODE_BINARY, MODE_CHASE} mode_t;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam logic [3:0] BAR_SEQ [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                         4'b1111, 4'b0111, 4'b0011, 4'b0001};
  localparam logic [3:0] CHASE_SEQ [6] = '{4'b0001, 4'b0010, 4'b0100,
                                           4'b1000, 4'b0100, 4'b0010};

  function automatic mode_t next_mode(mode_t m);
    case (m)
      MODE_OFF:    return MODE_BAR;
      MODE_BAR:    return MODE_BINARY;
      MODE_BINARY: return MODE_CHASE;
      default:     return MODE_OFF;
    endcase
  endfunction

  function automatic logic [3:0] first_pattern(mode_t m);
    case (m)
      MODE_BAR:   return BAR_SEQ[0];
      MODE_CHASE: return CHASE_SEQ[0];
      default:    return 4'b0000;
    endcase
  endfunction

  // Phase wraps at the length of the current mode's sequence.
  function automatic logic [3:0] next_phase(mode_t m, logic [3:0] p);
    case (m)
      MODE_BAR:    return (p >= 4'd7) ? 4'd0 : p + 4'd1;
      MODE_BINARY: return p + 4'd1;
      MODE_CHASE:  return (p >= 4'd5) ? 4'd0 : p + 4'd1;
      default:     return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] pattern_at(mode_t m, logic [3:0] p);
    case (m)
      MODE_BAR:    return BAR_SEQ[p[2:0]];
      MODE_BINARY: return p;
      MODE_CHASE:  return (p < 4'd6) ? CHASE_SEQ[p[2:0]] : 4'b0000;
      default:     return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_controller_if.sv
// Board-side bundle: raw buttons in, LED word and mode/run status out.
interface led_io_if #(parameter int W = 4);
  import led_ctrl_pkg::*;

  logic [3:0]   btn;
  logic [W-1:0] led;
  mode_t        mode;
  logic         running;

  modport master (output btn, input led, mode, running);
  modport slave  (input btn, output led, mode, running);
endinterface

// File: rtl/led_pattern_controller_btn_debounce.sv
// One button: 2-flop synchronizer, stability counter, and a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_COUNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_COUNT) + 1;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level_q, level_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized pin agrees with the accepted level restarts the count.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_COUNT - 1)) level_d = sync2_q;
      else                                  cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/led_pattern_controller.sv
// LED pattern scheduler: debounced buttons drive the mode FSM, speed, run/pause and phase restart.
module led_pattern_controller
  import led_ctrl_pkg::*;
#(
  parameter int COUNT_WIDTH    = 32,
  parameter int BASE_COUNT     = 25_000_000,
  parameter int DEBOUNCE_COUNT = 1_000_000,
  parameter int OUTPUT_WIDTH   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  led_io_if.slave  io
);
  mode_t                   mode_q, mode_d;
  logic                    running_q, running_d;
  logic [1:0]              speed_q, speed_d;
  logic [3:0]              phase_q, phase_d;
  logic [COUNT_WIDTH-1:0]  presc_q, presc_d;
  logic [OUTPUT_WIDTH-1:0] led_q, led_d;
  logic [3:0]              ev;
  logic [COUNT_WIDTH-1:0]  period;
  logic                    active, tick;

  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (io.btn[g]),
      .press   (ev[g])
    );
  end

  assign period = COUNT_WIDTH'(BASE_COUNT) >> speed_q;
  assign active = running_q && (mode_q != MODE_OFF);
  assign tick   = active && (presc_q == period - 1'b1);

  // Mode change beats phase restart beats tick; speed and run/pause apply alongside.
  always_comb begin
    mode_d    = mode_q;
    running_d = running_q;
    speed_d   = speed_q;
    phase_d   = phase_q;
    presc_d   = presc_q;
    led_d     = led_q;
    if (ev[1]) running_d = !running_q;
    if (ev[0]) begin
      mode_d  = next_mode(mode_q);
      phase_d = 4'd0;
      presc_d = '0;
      led_d   = first_pattern(next_mode(mode_q));
    end else if (ev[3]) begin
      phase_d = 4'd0;
      presc_d = '0;
      led_d   = first_pattern(mode_q);
    end else if (tick) begin
      phase_d = next_phase(mode_q, phase_q);
      presc_d = '0;
      led_d   = pattern_at(mode_q, next_phase(mode_q, phase_q));
    end else if (active) begin
      presc_d = presc_q + 1'b1;
    end
    if (ev[2]) begin
      speed_d = (speed_q == SPEED_MAX) ? 2'd0 : speed_q + 2'd1;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_BAR;
      running_q <= 1'b1;
      speed_q   <= 2'd0;
      phase_q   <= 4'd0;
      presc_q   <= '0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      running_q <= running_d;
      speed_q   <= speed_d;
      phase_q   <= phase_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
    end
  end

  assign io.led     = led_q;
  assign io.mode    = mode_q;
  assign io.running = running_q;
endmodule
